// File: rtl/maze_nav_ctrl.sv
// -----------------------------------------------------------------------------
// maze_nav_ctrl
// Maze-navigation controller. The IR line pattern is classified into five
// flags, and each flag is debounced. A wall-follow FSM then issues commands to
// the speedctl driver (continuous speed) or the stepctl driver (fixed step
// turns). The FSM uses the right-hand rule or the left-hand rule. It recovers
// with U-turns and detects the goal.
//
// Optional feature: define TURN_LOG_EN to keep a 16-bit history of turn
// decisions on turn_log. With TURN_LOG_EN undefined, turn_log is held at zero.
//
// Ports
//   WF_CLK      in   system clock
//   rst         in   synchronous active-high reset
//   start       in   go request, taken in IDLE. In DONE it returns to IDLE.
//   bump        in   bump switch; forces IDLE from any active state
//   ir_color    in   NCH line sensors, 1 = black, bit 0 = rightmost
//   step_done   in   stepctl pair idle
//   speed_en    out  enable speed-mode driver
//   step_en     out  one-cycle load pulse to stepctl
//   driver_sel  out  0 = speedctl drives motors, 1 = stepctl
//   dirL/dirR   out  wheel direction, 0 = forward
//   speedL/R    out  wheel speed command
//   degreeL/R   out  step target, valid with step_en
//   state       out  current FSM state code
//   lost_led    out  debounced lost flag
//   uturn_cnt   out  consecutive U-turns since the last junction turn
//   turn_log    out  turn history: 2 bits per entry, newest entry in [1:0]
// -----------------------------------------------------------------------------
module maze_nav_ctrl #(
    parameter int NCH        = 8,
    parameter int SPW        = 16,
    parameter int DEB_CYC    = 1600000,
    parameter int SPD_SEARCH = 360,
    parameter int SPD_FOLLOW = 180,
    parameter int DEG_OUT    = 240,
    parameter int DEG_UTURN  = 360,
    parameter int RULE       = 0,
    parameter int MAX_UTURN  = 3
) (
    input  logic                           WF_CLK,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           bump,
    input  logic [NCH-1:0]                 ir_color,
    input  logic                           step_done,
    output logic                           speed_en,
    output logic                           step_en,
    output logic                           driver_sel,
    output logic                           dirL,
    output logic                           dirR,
    output logic [SPW-1:0]                 speedL,
    output logic [SPW-1:0]                 speedR,
    output logic [SPW-1:0]                 degreeL,
    output logic [SPW-1:0]                 degreeR,
    output logic [3:0]                     state,
    output logic                           lost_led,
    output logic [$clog2(MAX_UTURN+1)-1:0] uturn_cnt,
    output logic [15:0]                    turn_log
);

    localparam int H  = NCH / 2;
    localparam int HW = $clog2(H + 1);
    localparam int UW = $clog2(MAX_UTURN + 1);
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_SEARCH = 4'd1, S_FOLLOW = 4'd2, S_ADJUST = 4'd3,
        S_TURN_R = 4'd4, S_TURN_L = 4'd5, S_UTURN = 4'd6, S_STEP_WAIT = 4'd7,
        S_DONE = 4'd8
    } state_t;

    // Flag vector layout: 0 ctr, 1 rall, 2 lall, 3 lost, 4 ok
    logic [H-2:0]  sym;
    logic [4:0]    raw_flags;
    logic [4:0]    deb_flags;
    logic [HW-1:0] lsum, rsum;

    // The pattern is symmetric about the centre pair. Mirror positions compare equal.
    genvar gi;
    generate
        for (gi = 0; gi < H - 1; gi++) begin : g_sym
            assign sym[gi] = (ir_color[H+1+gi] == ir_color[H-2-gi]);
        end
    endgenerate

    assign raw_flags[0] = ir_color[H-1] | ir_color[H];
    assign raw_flags[1] = &ir_color[H-1:0];
    assign raw_flags[2] = &ir_color[NCH-1:H];
    assign raw_flags[3] = ~|ir_color;
    assign raw_flags[4] = raw_flags[0] & (&sym);

    always_comb begin
        lsum = '0;
        rsum = '0;
        for (int i = 0; i < H; i++) begin
            rsum = rsum + HW'(ir_color[i]);
            lsum = lsum + HW'(ir_color[H+i]);
        end
    end

    // Each flag counts while its raw value disagrees with the debounced value.
    // The debounced value flips after DEB_CYC consecutive cycles of disagreement.
    generate
        for (gi = 0; gi < 5; gi++) begin : g_deb
            logic [DW-1:0] cnt_reg;
            logic          deb_reg;
            always_ff @(posedge WF_CLK) begin
                if (rst) begin
                    cnt_reg <= '0;
                    deb_reg <= 1'b0;
                end else if (raw_flags[gi] == deb_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DW'(DEB_CYC - 1)) begin
                    cnt_reg <= '0;
                    deb_reg <= raw_flags[gi];
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign deb_flags[gi] = deb_reg;
        end
    endgenerate

    logic ctr_deb, rall_deb, lall_deb, lost_deb, ok_deb, pref_deb, other_deb;
    assign ctr_deb   = deb_flags[0];
    assign rall_deb  = deb_flags[1];
    assign lall_deb  = deb_flags[2];
    assign lost_deb  = deb_flags[3];
    assign ok_deb    = deb_flags[4];
    assign pref_deb  = (RULE == 0) ? rall_deb : lall_deb;
    assign other_deb = (RULE == 0) ? lall_deb : rall_deb;

    state_t         state_reg, state_next;
    logic           sw_first_reg, sw_first_next;
    logic [UW-1:0]  uturn_cnt_reg, uturn_cnt_next, uturn_inc;
    logic           speed_en_reg, speed_en_next, step_en_reg, step_en_next;
    logic           driver_sel_reg, driver_sel_next;
    logic           dir_l_reg, dir_l_next, dir_r_reg, dir_r_next;
    logic [SPW-1:0] speed_l_reg, speed_l_next, speed_r_reg, speed_r_next;
    logic [SPW-1:0] degree_l_reg, degree_l_next, degree_r_reg, degree_r_next;
    logic           lost_led_reg;

    always_comb begin
        state_next     = state_reg;
        uturn_inc      = (uturn_cnt_reg == UW'(MAX_UTURN)) ? uturn_cnt_reg : uturn_cnt_reg + 1'b1;
        uturn_cnt_next = uturn_cnt_reg;
        case (state_reg)
            S_IDLE:      if (start && !bump) state_next = S_SEARCH;
            S_SEARCH:    if (ctr_deb) state_next = S_FOLLOW;
            S_FOLLOW: begin
                if (rall_deb && lall_deb)    state_next = S_DONE;
                else if (pref_deb)           state_next = (RULE == 0) ? S_TURN_R : S_TURN_L;
                else if (other_deb || ok_deb) state_next = S_FOLLOW;
                else if (lost_deb)           state_next = S_UTURN;
                else                         state_next = S_ADJUST;
            end
            S_ADJUST:    if (lsum == rsum) state_next = S_FOLLOW;
            S_TURN_R, S_TURN_L: begin
                uturn_cnt_next = '0;
                state_next     = S_STEP_WAIT;
            end
            S_UTURN: begin
                uturn_cnt_next = uturn_inc;
                state_next     = (uturn_inc == UW'(MAX_UTURN)) ? S_DONE : S_STEP_WAIT;
            end
            // The first cycle is skipped because stepctl has not yet seen the load pulse.
            S_STEP_WAIT: if (!sw_first_reg && step_done) state_next = S_FOLLOW;
            S_DONE: begin
                if (start) begin
                    state_next     = S_IDLE;
                    uturn_cnt_next = '0;
                end
            end
            default:     state_next = S_IDLE;
        endcase
        if (bump && state_reg != S_IDLE) state_next = S_IDLE;
        sw_first_next = (state_next == S_STEP_WAIT) && (state_reg != S_STEP_WAIT);
    end

    // Output decode of the current state. These values are registered, so each
    // state's commands appear one cycle after the state is entered.
    always_comb begin
        speed_en_next   = 1'b0;
        step_en_next    = 1'b0;
        driver_sel_next = 1'b0;
        dir_l_next      = 1'b0;
        dir_r_next      = 1'b0;
        speed_l_next    = '0;
        speed_r_next    = '0;
        degree_l_next   = '0;
        degree_r_next   = '0;
        case (state_reg)
            S_SEARCH, S_FOLLOW, S_ADJUST: begin
                speed_en_next = 1'b1;
                speed_l_next  = (state_reg == S_SEARCH) ? SPW'(SPD_SEARCH) : SPW'(SPD_FOLLOW);
                speed_r_next  = speed_l_next;
                if (state_reg == S_ADJUST) begin
                    // Pivot toward the heavier half. The wheel on that side runs in reverse.
                    if (lsum > rsum) dir_l_next = 1'b1;
                    else             dir_r_next = 1'b1;
                end
            end
            S_TURN_R, S_TURN_L, S_UTURN: begin
                step_en_next    = 1'b1;
                driver_sel_next = 1'b1;
                speed_l_next    = SPW'(SPD_FOLLOW);
                speed_r_next    = SPW'(SPD_FOLLOW);
                if (state_reg == S_UTURN) begin
                    degree_l_next = SPW'(DEG_UTURN);
                    degree_r_next = SPW'(DEG_UTURN);
                    dir_r_next    = 1'b1;
                end else if (state_reg == S_TURN_R) begin
                    degree_l_next = SPW'(DEG_OUT);
                    degree_r_next = SPW'(DEG_OUT / 2);
                    dir_r_next    = 1'b1;
                end else begin
                    degree_r_next = SPW'(DEG_OUT);
                    degree_l_next = SPW'(DEG_OUT / 2);
                    dir_l_next    = 1'b1;
                end
            end
            S_STEP_WAIT: begin
                driver_sel_next = 1'b1;
                dir_l_next      = dir_l_reg;
                dir_r_next      = dir_r_reg;
                speed_l_next    = speed_l_reg;
                speed_r_next    = speed_r_reg;
                degree_l_next   = degree_l_reg;
                degree_r_next   = degree_r_reg;
            end
            default: ;
        endcase
        if (bump && state_reg != S_IDLE) begin
            speed_en_next   = 1'b0;
            step_en_next    = 1'b0;
            driver_sel_next = 1'b0;
            dir_l_next      = 1'b0;
            dir_r_next      = 1'b0;
            speed_l_next    = '0;
            speed_r_next    = '0;
            degree_l_next   = '0;
            degree_r_next   = '0;
        end
    end

    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            sw_first_reg   <= 1'b0;
            uturn_cnt_reg  <= '0;
            speed_en_reg   <= 1'b0;
            step_en_reg    <= 1'b0;
            driver_sel_reg <= 1'b0;
            dir_l_reg      <= 1'b0;
            dir_r_reg      <= 1'b0;
            speed_l_reg    <= '0;
            speed_r_reg    <= '0;
            degree_l_reg   <= '0;
            degree_r_reg   <= '0;
            lost_led_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sw_first_reg   <= sw_first_next;
            uturn_cnt_reg  <= uturn_cnt_next;
            speed_en_reg   <= speed_en_next;
            step_en_reg    <= step_en_next;
            driver_sel_reg <= driver_sel_next;
            dir_l_reg      <= dir_l_next;
            dir_r_reg      <= dir_r_next;
            speed_l_reg    <= speed_l_next;
            speed_r_reg    <= speed_r_next;
            degree_l_reg   <= degree_l_next;
            degree_r_reg   <= degree_r_next;
            lost_led_reg   <= lost_deb;
        end
    end

`ifdef TURN_LOG_EN
    logic [15:0] turn_log_reg, turn_log_next;

    always_comb begin
        turn_log_next = turn_log_reg;
        case (state_reg)
            S_TURN_L: turn_log_next = {turn_log_reg[13:0], 2'd1};
            S_TURN_R: turn_log_next = {turn_log_reg[13:0], 2'd2};
            S_UTURN:  turn_log_next = {turn_log_reg[13:0], 2'd3};
            S_DONE:   if (start) turn_log_next = '0;
            default: ;
        endcase
    end

    always_ff @(posedge WF_CLK) begin
        if (rst) turn_log_reg <= '0;
        else     turn_log_reg <= turn_log_next;
    end

    assign turn_log = turn_log_reg;
`else
    assign turn_log = '0;
`endif

    assign state      = state_reg;
    assign speed_en   = speed_en_reg;
    assign step_en    = step_en_reg;
    assign driver_sel = driver_sel_reg;
    assign dirL       = dir_l_reg;
    assign dirR       = dir_r_reg;
    assign speedL     = speed_l_reg;
    assign speedR     = speed_r_reg;
    assign degreeL    = degree_l_reg;
    assign degreeR    = degree_r_reg;
    assign lost_led   = lost_led_reg;
    assign uturn_cnt  = uturn_cnt_reg;

endmodule

// File: tb/tb_maze_nav_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maze_nav_ctrl
// Two controllers share one stimulus stream. One uses the right-hand rule and
// the other uses the left-hand rule. DEB_CYC is 4 in both. A table of
// {ir pattern, step_done, hold cycles, expected outputs} drives the main
// sequence. Short hand-written sequences cover reset, start, bump and DONE exit.
// Expectations are queued when the stimulus is applied and are compared after
// the hold cycles have elapsed.
// -----------------------------------------------------------------------------
module tb_maze_nav_ctrl;

`ifdef TURN_LOG_EN
    localparam bit LOG_ON = 1'b1;
`else
    localparam bit LOG_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, bump, step_done;
    logic [7:0]  ir;

    logic        sen_r, ste_r, dsel_r, dl_r, dr_r, lost_r;
    logic [15:0] spl_r, spr_r, dgl_r, dgr_r, log_r;
    logic [3:0]  st_r;
    logic [1:0]  uc_r;
    logic        sen_l, ste_l, dsel_l, dl_l, dr_l, lost_l;
    logic [15:0] spl_l, spr_l, dgl_l, dgr_l, log_l;
    logic [3:0]  st_l;
    logic [1:0]  uc_l;

    always #5 clk = ~clk;

    maze_nav_ctrl #(.NCH(8), .SPW(16), .DEB_CYC(4), .RULE(0), .MAX_UTURN(3)) dut_r (
        .WF_CLK(clk), .rst(rst), .start(start), .bump(bump), .ir_color(ir),
        .step_done(step_done), .speed_en(sen_r), .step_en(ste_r), .driver_sel(dsel_r),
        .dirL(dl_r), .dirR(dr_r), .speedL(spl_r), .speedR(spr_r), .degreeL(dgl_r),
        .degreeR(dgr_r), .state(st_r), .lost_led(lost_r), .uturn_cnt(uc_r), .turn_log(log_r)
    );

    maze_nav_ctrl #(.NCH(8), .SPW(16), .DEB_CYC(4), .RULE(1), .MAX_UTURN(3)) dut_l (
        .WF_CLK(clk), .rst(rst), .start(start), .bump(bump), .ir_color(ir),
        .step_done(step_done), .speed_en(sen_l), .step_en(ste_l), .driver_sel(dsel_l),
        .dirL(dl_l), .dirR(dr_l), .speedL(spl_l), .speedR(spr_l), .degreeL(dgl_l),
        .degreeR(dgr_l), .state(st_l), .lost_led(lost_l), .uturn_cnt(uc_l), .turn_log(log_l)
    );

    typedef struct {
        string       name;
        int          sig;
        int unsigned exp;
    } exp_t;

    typedef struct {
        logic [7:0] ir;
        logic       sd;
        int hold;
        int st_r, st_l, np_r, np_l, sen_r, sen_l;
        int dgl_r, dgr_r, dl_r, dr_r, dgl_l, dgr_l, dl_l, dr_l;
        int ucnt, lost, log_r, log_l;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[12];
    int   checks   = 0;
    int   failures = 0;
    int   np_r     = 0;
    int   np_l     = 0;

    function automatic int unsigned get_sig(int sig);
        case (sig)
            0:  return st_r;
            1:  return st_l;
            2:  return np_r;
            3:  return np_l;
            4:  return sen_r;
            5:  return sen_l;
            6:  return dgl_r;
            7:  return dgr_r;
            8:  return dl_r;
            9:  return dr_r;
            10: return dgl_l;
            11: return dgr_l;
            12: return dl_l;
            13: return dr_l;
            14: return uc_r;
            15: return uc_l;
            16: return lost_r;
            17: return lost_l;
            18: return log_r;
            19: return log_l;
            20: return spl_r;
            21: return ste_r;
            22: return ste_l;
            23: return spr_r;
            default: return 32'hDEAD;
        endcase
    endfunction

    task automatic push(input string n, input int s, input int unsigned e);
        exp_t x;
        x.name = n;
        x.sig  = s;
        x.exp  = e;
        sbq.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        int unsigned act;
        while (sbq.size() > 0) begin
            x   = sbq.pop_front();
            act = get_sig(x.sig);
            checks++;
            if (act != x.exp) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d", x.name, act, x.exp);
            end
        end
    endtask

    // Advance n clocks. Outputs are sampled on the falling edge, and
    // step_en pulses are counted there.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (ste_r) np_r++;
            if (ste_l) np_l++;
        end
    endtask

    function automatic int unsigned lg(input int v);
        return LOG_ON ? v : 0;
    endfunction

    initial begin
        //            ir    sd hold st_r st_l np_r np_l sen_r sen_l dglr dgrr dlr drr dgll dgrl dll drl uc lost logr  logl
        tbl[0]  = '{8'h0F, 0, 10, 7, 2, 1, 0, 0, 1, 240, 120, 0, 1,   0,   0, 0, 0, 0, 0, 'h02, 'h00};
        tbl[1]  = '{8'h18, 0,  8, 7, 2, 0, 0, 0, 1, 240, 120, 0, 1,   0,   0, 0, 0, 0, 0, 'h02, 'h00};
        tbl[2]  = '{8'h18, 1,  4, 2, 2, 0, 0, 1, 1,   0,   0, 0, 0,   0,   0, 0, 0, 0, 0, 'h02, 'h00};
        tbl[3]  = '{8'hF0, 0, 10, 2, 7, 0, 1, 1, 0,   0,   0, 0, 0, 120, 240, 1, 0, 0, 0, 'h02, 'h01};
        tbl[4]  = '{8'h18, 0,  8, 2, 7, 0, 0, 1, 0,   0,   0, 0, 0, 120, 240, 1, 0, 0, 0, 'h02, 'h01};
        tbl[5]  = '{8'h18, 1,  4, 2, 2, 0, 0, 1, 1,   0,   0, 0, 0,   0,   0, 0, 0, 0, 0, 'h02, 'h01};
        tbl[6]  = '{8'h30, 0,  8, 3, 3, 0, 0, 1, 1,   0,   0, 1, 0,   0,   0, 1, 0, 0, 0, 'h02, 'h01};
        tbl[7]  = '{8'h18, 0,  8, 2, 2, 0, 0, 1, 1,   0,   0, 0, 0,   0,   0, 0, 0, 0, 0, 'h02, 'h01};
        tbl[8]  = '{8'h00, 0, 10, 7, 7, 1, 1, 0, 0, 360, 360, 0, 1, 360, 360, 0, 1, 1, 1, 'h0B, 'h07};
        tbl[9]  = '{8'h00, 1,  4, 7, 7, 1, 1, 0, 0, 360, 360, 0, 1, 360, 360, 0, 1, 2, 1, 'h2F, 'h1F};
        tbl[10] = '{8'h00, 1,  4, 8, 8, 1, 1, 0, 0,   0,   0, 0, 0,   0,   0, 0, 0, 3, 1, 'hBF, 'h7F};
        tbl[11] = '{8'h18, 0,  6, 8, 8, 0, 0, 0, 0,   0,   0, 0, 0,   0,   0, 0, 0, 3, 0, 'hBF, 'h7F};

        rst = 1'b1; start = 1'b0; bump = 1'b0; step_done = 1'b0; ir = 8'h18;
        tick(3);
        push("rst_state_r", 0, 0);  push("rst_state_l", 1, 0);
        push("rst_speed_en", 4, 0); push("rst_step_en", 21, 0);
        push("rst_speedL", 20, 0);  push("rst_uturn", 14, 0);
        push("rst_lost", 16, 0);    push("rst_log", 18, 0);
        drain();
        $display("reset: state_r=%0d state_l=%0d", st_r, st_l);

        rst = 1'b0; start = 1'b1;
        push("start_search_r", 0, 1); push("start_search_l", 1, 1);
        tick(1);
        drain();
        start = 1'b0;
        push("search_speedL", 20, 360); push("search_speed_en", 4, 1);
        tick(1);
        drain();
        push("follow_state_r", 0, 2); push("follow_state_l", 1, 2);
        push("follow_speedL", 20, 180); push("follow_speedR", 23, 180);
        push("follow_speed_en_r", 4, 1); push("follow_speed_en_l", 5, 1);
        tick(4);
        drain();
        $display("start: state_r=%0d speedL=%0d speedR=%0d", st_r, spl_r, spr_r);

        for (int i = 0; i < 12; i++) begin
            ir = tbl[i].ir;
            step_done = tbl[i].sd;
            np_r = 0;
            np_l = 0;
            push($sformatf("v%0d_state_r", i), 0, tbl[i].st_r);
            push($sformatf("v%0d_state_l", i), 1, tbl[i].st_l);
            push($sformatf("v%0d_pulses_r", i), 2, tbl[i].np_r);
            push($sformatf("v%0d_pulses_l", i), 3, tbl[i].np_l);
            push($sformatf("v%0d_speed_en_r", i), 4, tbl[i].sen_r);
            push($sformatf("v%0d_speed_en_l", i), 5, tbl[i].sen_l);
            push($sformatf("v%0d_degL_r", i), 6, tbl[i].dgl_r);
            push($sformatf("v%0d_degR_r", i), 7, tbl[i].dgr_r);
            push($sformatf("v%0d_dirL_r", i), 8, tbl[i].dl_r);
            push($sformatf("v%0d_dirR_r", i), 9, tbl[i].dr_r);
            push($sformatf("v%0d_degL_l", i), 10, tbl[i].dgl_l);
            push($sformatf("v%0d_degR_l", i), 11, tbl[i].dgr_l);
            push($sformatf("v%0d_dirL_l", i), 12, tbl[i].dl_l);
            push($sformatf("v%0d_dirR_l", i), 13, tbl[i].dr_l);
            push($sformatf("v%0d_uturn_r", i), 14, tbl[i].ucnt);
            push($sformatf("v%0d_uturn_l", i), 15, tbl[i].ucnt);
            push($sformatf("v%0d_lost_r", i), 16, tbl[i].lost);
            push($sformatf("v%0d_lost_l", i), 17, tbl[i].lost);
            push($sformatf("v%0d_log_r", i), 18, lg(tbl[i].log_r));
            push($sformatf("v%0d_log_l", i), 19, lg(tbl[i].log_l));
            push($sformatf("v%0d_step_en_r", i), 21, 0);
            tick(tbl[i].hold);
            drain();
            $display("vec %0d: ir=%h sd=%0d state_r=%0d state_l=%0d uturn=%0d log_r=%h log_l=%h",
                     i, tbl[i].ir, tbl[i].sd, st_r, st_l, uc_r, log_r, log_l);
        end

        // DONE exit on start clears the counters and the log
        start = 1'b1;
        push("done_exit_r", 0, 0); push("done_exit_l", 1, 0);
        push("done_clr_uturn", 14, 0); push("done_clr_log", 18, 0);
        tick(1);
        drain();
        $display("done exit: state_r=%0d uturn=%0d", st_r, uc_r);

        // Restart, take a right turn, then bump while in STEP_WAIT
        push("restart_search", 0, 1);
        tick(1);
        drain();
        start = 1'b0;
        push("restart_follow", 0, 2);
        tick(1);
        drain();
        ir = 8'h0F;
        push("turn2_wait_r", 0, 7); push("turn2_follow_l", 1, 2);
        push("turn2_log_r", 18, lg('h02));
        tick(8);
        drain();
        bump = 1'b1;
        push("bump_state_r", 0, 0); push("bump_state_l", 1, 0);
        push("bump_step_en_r", 21, 0); push("bump_step_en_l", 22, 0);
        push("bump_speed_en_r", 4, 0); push("bump_speed_en_l", 5, 0);
        tick(1);
        drain();
        $display("bump: state_r=%0d state_l=%0d", st_r, st_l);

        // start together with bump while IDLE: bump wins
        start = 1'b1;
        push("start_bump_r", 0, 0); push("start_bump_l", 1, 0);
        tick(1);
        drain();
        start = 1'b0; bump = 1'b0;
        push("idle_hold_r", 0, 0);
        tick(2);
        drain();
        $display("start+bump: state_r=%0d", st_r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
